// File: rtl/rv32i_types.sv
// rv32i_types
// Shared types for the mp3 pipelined core: the decoded control word, the
// RVFI monitor sidecar, and the per-stage record carried by ctrl_word_pipe.
// No ports; imported with `import rv32i_types::*;`.
package rv32i_types;

  // Decoded instruction control produced by the decode stage (32 bits).
  typedef struct packed {
    logic [6:0] opcode;
    logic [2:0] aluop;
    logic [2:0] cmpop;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       load_regfile;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
  } rv32i_control_word;

  // Formal-monitor sidecar that rides along with each instruction.
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [31:0] rd_wdata;
  } RVFIMonPacket;

  // One pipeline stage worth of state.
  typedef struct packed {
    logic              valid;
    rv32i_control_word ctrl;
    RVFIMonPacket      rvfi;
  } pipe_stage_t;

  // Largest supported ctrl_word_pipe DEPTH.
  localparam int PIPE_MAX_DEPTH = 8;

endpackage

// File: rtl/ctrl_pipe_stage.sv
// ctrl_pipe_stage
// One register stage of ctrl_word_pipe. On load it takes the incoming item's
// valid bit and, only if that item is live, its payload. While not loading it
// holds its payload and drops its valid bit if killed.
// Build option: RVFI_MON_EN -- when undefined the rvfi payload register is
// not built and q.rvfi is constant zero.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   load      take d this cycle (stage is empty or its item moves on)
//   kill      flush the item currently held
//   d         incoming stage record
//   q         registered stage record
module ctrl_pipe_stage
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        kill,
  input  pipe_stage_t d,
  output pipe_stage_t q
);

  logic              valid_q;
  rv32i_control_word ctrl_q;
  RVFIMonPacket      rvfi_w;

  // NOTE: sequential state is always written with non-blocking assignments so
  // every stage samples its neighbour's pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      // NOTE: payload registers are reset too, so out_ctrl reads zero after
      // reset rather than whatever was left in the pipe.
      ctrl_q  <= '0;
    end else if (load) begin
      valid_q <= d.valid;
      if (d.valid) ctrl_q <= d.ctrl;
    end else begin
      valid_q <= valid_q & ~kill;
    end
  end

`ifdef RVFI_MON_EN
  RVFIMonPacket rvfi_q;

  always_ff @(posedge clk) begin
    if (rst)                  rvfi_q <= '0;
    else if (load && d.valid) rvfi_q <= d.rvfi;
  end

  assign rvfi_w = rvfi_q;
`else
  // Monitor payload is discarded in this build.
  logic unused_rvfi;
  assign unused_rvfi = ^d.rvfi;
  assign rvfi_w      = '0;
`endif

  assign q = '{valid: valid_q, ctrl: ctrl_q, rvfi: rvfi_w};

endmodule

// File: rtl/ctrl_word_pipe.sv
// ctrl_word_pipe
// Elastic DEPTH-stage pipeline carrying an rv32i_control_word plus its
// RVFIMonPacket from decode towards execute/memory/writeback. A stall at the
// output only backs up as far as the nearest bubble, so gaps close up.
// Build option: RVFI_MON_EN -- builds the rvfi payload registers and the
// retire counter; when undefined out_rvfi and retire_count are zero.
// Parameters: DEPTH (1..PIPE_MAX_DEPTH), CNT_W (retire counter width).
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_ready      upstream handshake into stage 0
//   in_ctrl/in_rvfi        upstream payload
//   out_valid/out_ready    downstream handshake from stage DEPTH-1
//   out_ctrl/out_rvfi      stage DEPTH-1 payload (shown even when not valid)
//   flush_mask             bit i kills the item held in stage i this cycle
//   occupancy              number of set stage valid bits (pre-flush)
//   retire_count           output handshakes since reset, wrapping
module ctrl_word_pipe
  import rv32i_types::*;
#(
  parameter int DEPTH = 3,
  parameter int CNT_W = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  rv32i_control_word            in_ctrl,
  input  RVFIMonPacket                 in_rvfi,
  output logic                         out_valid,
  input  logic                         out_ready,
  output rv32i_control_word            out_ctrl,
  output RVFIMonPacket                 out_rvfi,
  input  logic [DEPTH-1:0]             flush_mask,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic [CNT_W-1:0]             retire_count
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  pipe_stage_t      stage_d [DEPTH];
  pipe_stage_t      stage_q [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] veff;
  logic [DEPTH-1:0] rdy;

  // A flushed item is invisible to the ready chain and the output.
  assign veff = valid & ~flush_mask;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign stage_d[i] = '{valid: in_valid, ctrl: in_ctrl, rvfi: in_rvfi};
    end else begin : g_body
      assign stage_d[i] = '{valid: veff[i-1],
                            ctrl:  stage_q[i-1].ctrl,
                            rvfi:  stage_q[i-1].rvfi};
    end

    // Stage i can load when any stage from i to the output holds a bubble,
    // or the output is draining: the unrolled form of
    // rdy[i] = ~veff[i] | rdy[i+1].
    assign rdy[i] = out_ready | ~(&veff[DEPTH-1:i]);

    ctrl_pipe_stage u_stage (
      .clk  (clk),
      .rst  (rst),
      .load (rdy[i]),
      .kill (flush_mask[i]),
      .d    (stage_d[i]),
      .q    (stage_q[i])
    );

    assign valid[i] = stage_q[i].valid;
  end

  assign in_ready  = rdy[0];
  assign out_valid = veff[DEPTH-1];
  assign out_ctrl  = stage_q[DEPTH-1].ctrl;
  // Constant zero when the monitor registers are not built.
  assign out_rvfi  = stage_q[DEPTH-1].rvfi;

  // Occupancy counts raw valid bits, so a stage being flushed this cycle
  // still counts until the edge clears it.
  logic [OCC_W-1:0] occ_sum;
  always_comb begin
    // NOTE: assigning a default before the loop keeps this purely
    // combinational; no path leaves occ_sum unassigned, so no latch.
    occ_sum = '0;
    for (int i = 0; i < DEPTH; i++) occ_sum = occ_sum + OCC_W'(valid[i]);
  end
  assign occupancy = occ_sum;

`ifdef RVFI_MON_EN
  logic [CNT_W-1:0] retire_d;
  logic [CNT_W-1:0] retire_q;

  assign retire_d = (out_valid && out_ready) ? retire_q + CNT_W'(1) : retire_q;

  always_ff @(posedge clk) begin
    if (rst) retire_q <= '0;
    else     retire_q <= retire_d;
  end

  assign retire_count = retire_q;
`else
  assign retire_count = '0;
`endif

endmodule

// File: tb/tb_ctrl_word_pipe.sv
// tb_ctrl_word_pipe
// Self-checking bench for ctrl_word_pipe (DEPTH=3). A reference model tracks
// which slots hold which items and moves items forward whenever any hole lies
// ahead of them (or the output drains). Directed scenarios are followed by a
// long randomized run, all checked against the model.
module tb_ctrl_word_pipe;
  import rv32i_types::*;

  localparam int D  = 3;
  localparam int CW = 64;
  localparam int OW = $clog2(D + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  rv32i_control_word in_ctrl;
  RVFIMonPacket      in_rvfi;
  logic              out_valid;
  logic              out_ready;
  rv32i_control_word out_ctrl;
  RVFIMonPacket      out_rvfi;
  logic [D-1:0]      flush_mask;
  logic [OW-1:0]     occupancy;
  logic [CW-1:0]     retire_count;

  always #5 clk = ~clk;

  ctrl_word_pipe #(.DEPTH(D), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_ctrl      (in_ctrl),
    .in_rvfi      (in_rvfi),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_ctrl     (out_ctrl),
    .out_rvfi     (out_rvfi),
    .flush_mask   (flush_mask),
    .occupancy    (occupancy),
    .retire_count (retire_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: slot contents, not register encodings.
  bit                m_occ  [D];
  rv32i_control_word m_ctrl [D];
  RVFIMonPacket      m_rvfi [D];
  logic [CW-1:0]     m_cnt;
  bit                last_acc;

  function automatic rv32i_control_word rand_ctrl();
    return rv32i_control_word'($urandom);
  endfunction

  function automatic RVFIMonPacket rand_rvfi();
    return RVFIMonPacket'({$urandom, $urandom, $urandom, $urandom});
  endfunction

  function automatic rv32i_control_word ctrl_rd(input int rd);
    rv32i_control_word c;
    c    = rand_ctrl();
    c.rd = 5'(rd);
    return c;
  endfunction

  // One clock: drive at negedge, check combinational and registered outputs
  // against the model, then advance the model across the posedge.
  task automatic step(input bit r, input bit v, input rv32i_control_word c,
                      input RVFIMonPacket f, input bit ordy, input logic [D-1:0] fm);
    bit                live  [D];
    bit                adv   [D];
    bit                n_occ [D];
    rv32i_control_word n_ctrl[D];
    RVFIMonPacket      n_rvfi[D];
    bit                hole;
    bit                exp_ir;
    bit                exp_ov;
    int                occ_cnt;
    @(negedge clk);
    rst = r; in_valid = v; in_ctrl = c; in_rvfi = f; out_ready = ordy; flush_mask = fm;
    #1;
    occ_cnt = 0;
    hole    = 1'b0;
    for (int i = 0; i < D; i++) begin
      live[i] = m_occ[i] && !fm[i];
      occ_cnt += int'(m_occ[i]);
      if (!live[i]) hole = 1'b1;
    end
    for (int i = 0; i < D; i++) begin
      adv[i] = ordy;
      for (int j = i + 1; j < D; j++) if (!live[j]) adv[i] = 1'b1;
    end
    exp_ir = ordy || hole;
    exp_ov = live[D-1];
    check("in_ready", in_ready, exp_ir);
    check("out_valid", out_valid, exp_ov);
    check("occupancy", occupancy, occ_cnt);
    if (exp_ov) check("out_ctrl", out_ctrl, m_ctrl[D-1]);
`ifdef RVFI_MON_EN
    if (exp_ov) check("out_rvfi", out_rvfi, m_rvfi[D-1]);
    check("retire_count", retire_count, m_cnt);
`else
    check("out_rvfi_zero", out_rvfi, '0);
    check("retire_count_zero", retire_count, '0);
`endif
    for (int i = 0; i < D; i++) begin
      n_occ[i]  = 1'b0;
      n_ctrl[i] = m_ctrl[i];
      n_rvfi[i] = m_rvfi[i];
    end
    for (int i = 0; i < D; i++) begin
      if (live[i]) begin
        if (adv[i] && i == D - 1) begin
          m_cnt = m_cnt + 1;
        end else if (adv[i]) begin
          n_occ[i+1] = 1'b1; n_ctrl[i+1] = m_ctrl[i]; n_rvfi[i+1] = m_rvfi[i];
        end else begin
          n_occ[i] = 1'b1;
        end
      end
    end
    last_acc = !r && v && exp_ir;
    if (last_acc) begin
      n_occ[0] = 1'b1; n_ctrl[0] = c; n_rvfi[0] = f;
    end
    for (int i = 0; i < D; i++) begin
      m_occ[i]  = r ? 1'b0 : n_occ[i];
      m_ctrl[i] = r ? '0 : n_ctrl[i];
      m_rvfi[i] = r ? '0 : n_rvfi[i];
    end
    if (r) m_cnt = '0;
    @(posedge clk);
  endtask

  task automatic idle(input bit ordy, input logic [D-1:0] fm);
    step(1'b0, 1'b0, '0, '0, ordy, fm);
  endtask

  rv32i_control_word a_c, b_c, c_c, pend_c;
  RVFIMonPacket      pend_r;
  rv32i_control_word bp [4];
  bit                pend;
  bit                r_bit;
  logic [D-1:0]      fm_r;
  logic [CW-1:0]     cnt_base;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_ctrl = '0; in_rvfi = '0;
    out_ready = 1'b0; flush_mask = '0;
    for (int i = 0; i < D; i++) begin
      m_occ[i] = 1'b0; m_ctrl[i] = '0; m_rvfi[i] = '0;
    end
    m_cnt = '0;

    // Reset held for two cycles.
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_occupancy", occupancy, 0);
    check("rst_out_ctrl", out_ctrl, '0);
    check("rst_out_rvfi", out_rvfi, '0);
    check("rst_retire_count", retire_count, '0);

    // Streaming rd=1..5 back-to-back, output always ready.
    for (int k = 1; k <= 5; k++) step(1'b0, 1'b1, ctrl_rd(k), rand_rvfi(), 1'b1, '0);
    repeat (4) idle(1'b1, '0);
    #1;
`ifdef RVFI_MON_EN
    check("stream_retired", retire_count, 5);
`else
    check("stream_retired", retire_count, 0);
`endif

    // Backpressure: four offers with the output stalled.
    step(1'b1, 1'b0, '0, '0, 1'b0, '0);
    for (int k = 0; k < 4; k++) bp[k] = ctrl_rd(k + 1);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, bp[k], '0, 1'b0, '0);
    #1;
    check("bp_occupancy", occupancy, 3);
    check("bp_in_ready", in_ready, 1'b0);
    check("bp_head", out_ctrl, bp[0]);
    pend = !last_acc;
    for (int k = 0; k < 8; k++) begin
      step(1'b0, pend, bp[3], '0, 1'b1, '0);
      if (last_acc) pend = 1'b0;
    end

    // Bubble collapse with the output stalled.
    step(1'b1, 1'b0, '0, '0, 1'b0, '0);
    a_c = ctrl_rd(10); b_c = ctrl_rd(11); c_c = ctrl_rd(12);
    step(1'b0, 1'b1, a_c, '0, 1'b0, '0);
    idle(1'b0, '0);
    step(1'b0, 1'b1, b_c, '0, 1'b0, '0);
    idle(1'b0, '0);
    #1;
    check("bubble_occupancy", occupancy, 2);
    check("bubble_in_ready", in_ready, 1'b1);
    check("bubble_head", out_ctrl, a_c);

    // Flush of stages 0 and 1 in a full pipe.
    step(1'b1, 1'b0, '0, '0, 1'b0, '0);
    step(1'b0, 1'b1, a_c, '0, 1'b0, '0);
    step(1'b0, 1'b1, b_c, '0, 1'b0, '0);
    step(1'b0, 1'b1, c_c, '0, 1'b0, '0);
    idle(1'b0, 3'b011);
    #1;
    check("flush_occupancy", occupancy, 1);
    check("flush_survivor", out_ctrl, a_c);
    repeat (4) idle(1'b1, '0);

    // Kill at the output while downstream is ready.
    step(1'b1, 1'b0, '0, '0, 1'b0, '0);
    step(1'b0, 1'b1, a_c, '0, 1'b0, '0);
    repeat (2) idle(1'b0, '0);
    idle(1'b1, 3'b100);
    #1;
    check("kill_occupancy", occupancy, 0);
    check("kill_retire_count", retire_count, '0);
    cnt_base = retire_count;
    check("kill_cnt_base_zero", cnt_base, '0);

    // Randomized run, including occasional mid-stream resets.
    pend = 1'b0;
    pend_c = '0;
    pend_r = '0;
    for (int n = 0; n < 3000; n++) begin
      r_bit = ($urandom_range(0, 199) == 0);
      if (!pend && $urandom_range(0, 3) != 0) begin
        pend = 1'b1; pend_c = rand_ctrl(); pend_r = rand_rvfi();
      end
      for (int i = 0; i < D; i++) fm_r[i] = ($urandom_range(0, 11) == 0);
      step(r_bit, pend, pend_c, pend_r, $urandom_range(0, 2) != 0, fm_r);
      if (last_acc) pend = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ctrl_word_pipe.md
# ctrl_word_pipe

Parametrised elastic pipeline that carries a decoded `rv32i_control_word` and its `RVFIMonPacket` sidecar through `DEPTH` register stages. Each stage has its own valid bit and a per-stage flush. A stall at the output backs up only as far as the first bubble, so gaps close up instead of propagating. It sits between decode and the execute/memory/writeback stages of the mp3 pipelined core and replaces hand-written per-stage control registers. Stage 0 is the input side; stage `DEPTH-1` is the output side.

## Interface
- `DEPTH`, 3: number of register stages, legal range 1..8.
- `CNT_W`, 64: width of the retire counter.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `in_valid`  in  1  upstream offers an item.
- `in_ready`  out  1  stage 0 can accept this cycle.
- `in_ctrl`  in  `rv32i_control_word`  control payload.
- `in_rvfi`  in  `RVFIMonPacket`  monitor payload.
- `out_valid`  out  1  stage `DEPTH-1` presents a live item.
- `out_ready`  in  1  downstream consumes; low means stall.
- `out_ctrl`  out  `rv32i_control_word`  stage `DEPTH-1` control payload.
- `out_rvfi`  out  `RVFIMonPacket`  stage `DEPTH-1` monitor payload.
- `flush_mask`  in  `DEPTH`  bit i kills the item held in stage i this cycle.
- `occupancy`  out  `$clog2(DEPTH+1)`  count of set stage valid bits.
- `retire_count`  out  `CNT_W`  number of output handshakes since reset.

## Operation
- Per-stage registers: `valid[i]`, `ctrl[i]`, `rvfi[i]`.
- Effective valid: `veff[i] = valid[i] & ~flush_mask[i]`. A flushed item never advances and is never presented at the output.
- Ready chain: `rdy[DEPTH-1] = ~veff[DEPTH-1] | out_ready`; `rdy[i] = ~veff[i] | rdy[i+1]`; `in_ready = rdy[0]`.
- Stage i loads from stage i-1 (or from the input when i=0) when `rdy[i]`. The new `valid[i]` is `veff[i-1]` (or `in_valid`). Payload registers load only when the incoming item is valid; otherwise they hold.
- When `rdy[i]` is 0, stage i holds. Its valid bit becomes `veff[i]`, so a flushed, stalled item is cleared.
- `out_valid = veff[DEPTH-1]`. `out_ctrl` and `out_rvfi` always reflect the stage `DEPTH-1` registers, regardless of valid.
- Handshake: a transfer occurs on `out_valid & out_ready`. `retire_count` increments by 1 per transfer and wraps at 2^`CNT_W`.
- `occupancy` is the popcount of the `valid` registers, before the flush mask is applied.
- Ordering: items leave in acceptance order. Nothing is duplicated. The only way an item is dropped is through `flush_mask`.

## Timing
- Reset (`rst` high at an edge): all `valid`=0, all payload registers=0, `retire_count`=0. After the edge: `out_valid`=0, `in_ready`=1, `occupancy`=0, `out_ctrl`=0, `out_rvfi`=0.
- `rst` overrides `flush_mask`, `in_valid` and `out_ready`. A reset mid-stream discards every stage.
- Latency: an item accepted at edge t is at the output after edge t+DEPTH-1 when unstalled. With `DEPTH`=1 the item is visible the cycle after acceptance.
- Throughput: one item per cycle while `out_ready`=1.
- Full pipe with `out_ready`=1: `in_ready`=1, and simultaneous accept and retire keep `occupancy` constant.
- Combinational paths: `out_ready`→`in_ready` and `flush_mask`→`in_ready`/`out_valid`. There is no path from `in_valid` to `in_ready`.
- Upstream must hold `in_valid`/`in_ctrl`/`in_rvfi` stable until `in_ready`. The block does not check this.

## Configuration
- `RVFI_MON_EN` defined: `rvfi[i]` registers and `retire_count` are built as described above.
- `RVFI_MON_EN` undefined: no `rvfi` registers and no counter are synthesised. `out_rvfi` is tied to 0, `retire_count` is tied to 0, and `in_rvfi` is ignored.
- Ports are identical in both builds. Control-word behaviour is unchanged in both builds.

## Structure
- Add to `rv32i_types`:
  - `typedef struct packed { logic valid; rv32i_control_word ctrl; RVFIMonPacket rvfi; } pipe_stage_t;`
  - `localparam int PIPE_MAX_DEPTH = 8;`
- Sub-module `ctrl_pipe_stage`: one register stage with inputs `clk`, `rst`, `load`, `kill`, `d` (`pipe_stage_t`) and output `q`. It is instantiated `DEPTH` times in a generate loop.
- The ready chain, occupancy popcount and counter live in the top module.

## Test plan
- Reset: hold `rst`=1 for 2 cycles → `out_valid`=0, `in_ready`=1, `occupancy`=0, `out_ctrl`=0, `retire_count`=0.
- Streaming, `DEPTH`=3, `out_ready`=1: push `ctrl.rd`=1..5 back-to-back → `out_valid` first seen 2 cycles after the first acceptance; rd 1,2,3,4,5 appear on consecutive cycles; `retire_count`=5.
- Backpressure, `out_ready`=0: offer 4 items → 3 accepted, `in_ready`=0, `occupancy`=3. Raise `out_ready` → items 1..4 emerge in order.
- Bubble collapse, `out_ready`=0: push A, idle 1 cycle, push B → within 2 cycles A and B occupy stages 2 and 1 (contiguous), `occupancy`=2, `in_ready`=1.
- Flush: pipe full, stage0=C, stage1=B, stage2=A; pulse `flush_mask`=3'b011 → next cycle `occupancy`=1; only A emerges; B and C never appear.
- Kill at output: `out_valid`=1, `out_ready`=1, `flush_mask`[2]=1 → no transfer, `out_valid`=0 that cycle, `retire_count` unchanged. Without `RVFI_MON_EN`: `out_rvfi`=0 and `retire_count`=0 throughout.
